// File: rtl/task3.sv
// Circle-drawing engine for a 160x120, 3-bit-colour VGA framebuffer adapter.
// After reset it clears the screen to black. Each rising `draw` request
// rasterises one midpoint circle, centred on the screen, in the latched colour.
module task3 #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int CENTRE_X = 80,
    parameter int CENTRE_Y = 60
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [4:0] radius,
    input  logic [2:0] colour_inp,
    input  logic       draw,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_CIRCLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic signed [9:0] CX = 10'(CENTRE_X);
    localparam logic signed [9:0] CY = 10'(CENTRE_Y);
    localparam logic [7:0] CLR_X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] CLR_Y_LAST = 7'(SCREEN_H - 1);

    state_t state, state_nxt;

    // Screen-clear scan position
    logic [7:0] clr_x;
    logic [6:0] clr_y;
    logic       clr_last;

    // Midpoint circle state: offsets are signed because ox may step below zero
    // on the final update (e.g. radius 0), which is what terminates the loop.
    logic signed [6:0] ox, oy;
    logic signed [8:0] crit;
    logic [2:0]        oct;
    logic [2:0]        col_l;

    // Values the circle state takes after the current iteration
    logic signed [6:0] ox_upd, oy_upd;
    logic signed [8:0] crit_upd;
    logic              circle_end;

    // Selected octant point at full width
    logic signed [9:0] ox10, oy10;
    logic signed [9:0] pt_x, pt_y;

    // Next values for the registered outputs
    logic [7:0] x_nxt;
    logic [6:0] y_nxt;
    logic [2:0] col_nxt;
    logic       plot_nxt;

    // Coordinates are formed at full width and simply truncated; every point of
    // a radius <= 31 circle about the centre lies on screen.
    function automatic logic [7:0] to_x(input logic signed [9:0] v);
        return 8'(v);
    endfunction

    function automatic logic [6:0] to_y(input logic signed [9:0] v);
        return 7'(v);
    endfunction

    assign clr_last = (clr_x == CLR_X_LAST) && (clr_y == CLR_Y_LAST);
    assign ox10     = 10'(ox);
    assign oy10     = 10'(oy);

    // State register; reset restarts the screen clear from any state
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Midpoint iteration update, evaluated with the new oy (and new ox)
    always_comb begin
        oy_upd   = oy + 7'sd1;
        ox_upd   = ox;
        crit_upd = crit;
        if (crit <= 9'sd0) begin
            crit_upd = crit + (9'(oy_upd) <<< 1) + 9'sd1;
        end else begin
            ox_upd   = ox - 7'sd1;
            crit_upd = crit + (9'(oy_upd) <<< 1) - (9'(ox_upd) <<< 1) + 9'sd1;
        end
        circle_end = (oy_upd > ox_upd);
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR:  if (clr_last) state_nxt = S_IDLE;
            S_IDLE:   if (draw) state_nxt = S_CIRCLE;
            S_CIRCLE: if ((oct == 3'd7) && circle_end) state_nxt = S_DONE;
            S_DONE:   if (!draw) state_nxt = S_IDLE;
            default:  state_nxt = S_CLEAR;
        endcase
    end

    // Octant point for the current plot cycle of an iteration
    always_comb begin
        pt_x = CX;
        pt_y = CY;
        case (oct)
            3'd0: begin pt_x = CX + ox10; pt_y = CY + oy10; end
            3'd1: begin pt_x = CX + oy10; pt_y = CY + ox10; end
            3'd2: begin pt_x = CX - ox10; pt_y = CY + oy10; end
            3'd3: begin pt_x = CX - oy10; pt_y = CY + ox10; end
            3'd4: begin pt_x = CX - ox10; pt_y = CY - oy10; end
            3'd5: begin pt_x = CX - oy10; pt_y = CY - ox10; end
            3'd6: begin pt_x = CX + ox10; pt_y = CY - oy10; end
            default: begin pt_x = CX + oy10; pt_y = CY - ox10; end
        endcase
    end

    // Output logic: what the pixel port shows on the next cycle
    always_comb begin
        x_nxt    = vga_x;
        y_nxt    = vga_y;
        col_nxt  = vga_colour;
        plot_nxt = 1'b0;
        case (state)
            S_CLEAR: begin
                x_nxt    = clr_x;
                y_nxt    = clr_y;
                col_nxt  = 3'b000;
                plot_nxt = 1'b1;
            end
            S_CIRCLE: begin
                x_nxt    = to_x(pt_x);
                y_nxt    = to_y(pt_y);
                col_nxt  = col_l;
                plot_nxt = 1'b1;
            end
            default: begin
                plot_nxt = 1'b0;
            end
        endcase
    end

    // Registered pixel port
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
        end else begin
            vga_x      <= x_nxt;
            vga_y      <= y_nxt;
            vga_colour <= col_nxt;
            vga_plot   <= plot_nxt;
        end
    end

    // Clear scan counters: y inner, x outer
    always_ff @(posedge clk) begin
        if (!rstn) begin
            clr_x <= 8'd0;
            clr_y <= 7'd0;
        end else if (state == S_CLEAR) begin
            if (clr_y == CLR_Y_LAST) begin
                clr_y <= 7'd0;
                clr_x <= clr_x + 8'd1;
            end else begin
                clr_y <= clr_y + 7'd1;
            end
        end
    end

    // Circle datapath: latch request in IDLE, step octant and iterate in CIRCLE
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (draw) begin
                col_l <= colour_inp;
                ox    <= $signed({2'b00, radius});
                oy    <= 7'sd0;
                crit  <= 9'sd1 - $signed({4'b0000, radius});
                oct   <= 3'd0;
            end
        end else if (state == S_CIRCLE) begin
            oct <= oct + 3'd1;
            if (oct == 3'd7) begin
                ox   <= ox_upd;
                oy   <= oy_upd;
                crit <= crit_upd;
            end
        end
    end

endmodule

// File: tb/tb_task3.sv
// Directed bench for the task3 circle engine: screen clear, table of small
// circles, explicit radius-1 pixel sequence, large held-draw circle, latched
// parameters, draw during clear and reset mid-circle.
module tb_task3;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [4:0] radius = 5'd0;
    logic [2:0] colour_inp = 3'd0;
    logic       draw = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    task3 dut (
        .clk        (clk),
        .rstn       (rstn),
        .radius     (radius),
        .colour_inp (colour_inp),
        .draw       (draw),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    typedef struct {
        logic [4:0] r;
        logic [2:0] c;
        int         exp_n;
    } vec_t;

    pix_t q[$];
    int   nvec = 0;
    int   nfail = 0;

    // Capture every plotted pixel away from the active edge
    always @(negedge clk) begin
        if (vga_plot === 1'b1) q.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour)});
    end

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_draw(input logic [4:0] r, input logic [2:0] c);
        radius     = r;
        colour_inp = c;
        draw       = 1'b1;
        tick(1);
        draw = 1'b0;
    endtask

    function automatic pix_t get(input int idx);
        pix_t p;
        p = '{-1, -1, -1};
        if (idx < q.size()) p = q[idx];
        return p;
    endfunction

    function automatic int enc(input pix_t p);
        return p.x * 256 + p.y;
    endfunction

    task automatic check_clear(input string tag);
        int idx, bad_order, bad_col;
        pix_t p;
        chk({tag, "_count"}, q.size(), 19200);
        chk({tag, "_px0"}, enc(get(0)), 0 * 256 + 0);
        chk({tag, "_px1"}, enc(get(1)), 0 * 256 + 1);
        chk({tag, "_px120"}, enc(get(120)), 1 * 256 + 0);
        chk({tag, "_px_last"}, enc(get(19199)), 159 * 256 + 119);
        idx = 0;
        bad_order = 0;
        bad_col = 0;
        for (int x = 0; x < 160; x++) begin
            for (int y = 0; y < 120; y++) begin
                p = get(idx);
                if (p.x != x || p.y != y) bad_order++;
                if (p.c != 0) bad_col++;
                idx++;
            end
        end
        chk({tag, "_order_errs"}, bad_order, 0);
        chk({tag, "_colour_errs"}, bad_col, 0);
        chk({tag, "_plot_after"}, int'(vga_plot), 0);
    endtask

    // Points off the ideal circle by more than 2r in squared distance
    function automatic int off_circle(input int r);
        int bad, dx, dy, d;
        bad = 0;
        foreach (q[i]) begin
            dx = q[i].x - 80;
            dy = q[i].y - 60;
            d  = dx * dx + dy * dy - r * r;
            if (d < 0) d = -d;
            if (d > 2 * r) bad++;
        end
        return bad;
    endfunction

    function automatic int colour_errs(input int c);
        int bad;
        bad = 0;
        foreach (q[i]) if (q[i].c != c) bad++;
        return bad;
    endfunction

    function automatic int seen(input int x, input int y);
        foreach (q[i]) if (q[i].x == x && q[i].y == y) return 1;
        return 0;
    endfunction

    vec_t vecs[5];
    int   r1_x[16];
    int   r1_y[16];
    int   n31;

    initial begin
        vecs[0] = '{5'd0, 3'b101, 8};
        vecs[1] = '{5'd1, 3'b010, 16};
        vecs[2] = '{5'd2, 3'b011, 16};
        vecs[3] = '{5'd3, 3'b110, 24};
        vecs[4] = '{5'd5, 3'b111, 32};
        r1_x = '{81, 80, 79, 80, 79, 80, 81, 80, 81, 81, 79, 79, 79, 79, 81, 81};
        r1_y = '{60, 61, 60, 61, 60, 59, 60, 59, 61, 61, 61, 61, 59, 59, 59, 59};

        // Reset state
        rstn = 1'b0;
        tick(2);
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_x", int'(vga_x), 0);
        chk("rst_y", int'(vga_y), 0);
        chk("rst_colour", int'(vga_colour), 0);

        // Full clear after release, then silence
        q.delete();
        rstn = 1'b1;
        tick(19300);
        check_clear("clear");

        // Table of small circles
        for (int i = 0; i < 5; i++) begin
            q.delete();
            pulse_draw(vecs[i].r, vecs[i].c);
            tick(300);
            chk($sformatf("r%0d_count", vecs[i].r), q.size(), vecs[i].exp_n);
            chk($sformatf("r%0d_first", vecs[i].r), enc(get(0)), (80 + int'(vecs[i].r)) * 256 + 60);
            chk($sformatf("r%0d_colour_errs", vecs[i].r), colour_errs(int'(vecs[i].c)), 0);
            chk($sformatf("r%0d_off_circle", vecs[i].r), off_circle(int'(vecs[i].r)), 0);
        end

        // Radius 1: exact pixel order
        q.delete();
        pulse_draw(5'd1, 3'b010);
        tick(100);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("r1_seq_px%0d", i), enc(get(i)), r1_x[i] * 256 + r1_y[i]);
        end

        // Radius 31 with draw held: one circle only
        q.delete();
        radius = 5'd31;
        colour_inp = 3'b101;
        draw = 1'b1;
        tick(1000);
        n31 = q.size();
        chk("r31_count_mod8", n31 % 8, 0);
        chk("r31_nonempty", int'(n31 >= 8), 1);
        chk("r31_off_circle", off_circle(31), 0);
        chk("r31_colour_errs", colour_errs(5), 0);
        chk("r31_has_111_60", seen(111, 60), 1);
        chk("r31_has_80_91", seen(80, 91), 1);
        chk("r31_has_49_60", seen(49, 60), 1);
        chk("r31_has_80_29", seen(80, 29), 1);
        draw = 1'b0;
        tick(20);
        chk("r31_no_repeat_after_drop", q.size(), n31);
        pulse_draw(5'd31, 3'b101);
        tick(400);
        chk("r31_redraw_count", q.size(), 2 * n31);

        // Inputs changed mid-draw keep the latched values
        q.delete();
        pulse_draw(5'd3, 3'b011);
        radius = 5'd31;
        colour_inp = 3'b111;
        tick(300);
        chk("latch_count", q.size(), 24);
        chk("latch_colour_errs", colour_errs(3), 0);
        chk("latch_off_circle", off_circle(3), 0);

        // Reset mid-circle, then draw held during the restarted clear
        q.delete();
        pulse_draw(5'd31, 3'b110);
        tick(20);
        rstn = 1'b0;
        tick(1);
        chk("midrst_plot", int'(vga_plot), 0);
        chk("midrst_x", int'(vga_x), 0);
        chk("midrst_y", int'(vga_y), 0);
        chk("midrst_colour", int'(vga_colour), 0);
        q.delete();
        rstn = 1'b1;
        draw = 1'b1;
        tick(100);
        draw = 1'b0;
        tick(19200);
        check_clear("clear2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
